// File: rtl/l1_cache_pkg.sv
// Shared types for the l1_cache block: line geometry, FSM states and the request record.
package cache_types;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_W    = 5;
  localparam int LINE_BYTES  = LINE_BITS / 8;
  localparam int LINE_ADDR_W = 32 - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } cache_state_t;

  // tag and index are held zero-extended to the full line-address width so the
  // record layout does not depend on the number of sets.
  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [LINE_ADDR_W-1:0] tag;
    logic [LINE_ADDR_W-1:0] index;
    logic [2:0]             word;
    logic [3:0]             be;
    logic [31:0]            wdata;
  } cache_req_t;

endpackage

// File: rtl/l1_cache_array.sv
// Storage for l1_cache: valid/dirty/tag/data per set, asynchronous read, synchronous
// byte-masked write and whole-line fill, all addressed by a single set index.
module l1_cache_array
  import cache_types::*;
#(
  parameter int SETS  = 32,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = LINE_ADDR_W - IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [LINE_BYTES-1:0] wr_mask,
  input  logic [LINE_BITS-1:0]  wr_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_BITS-1:0]  fill_data,
  input  logic                  clean_en
);

  logic [SETS-1:0]      valid_q, valid_d;
  logic [SETS-1:0]      dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];
  logic [LINE_BITS-1:0] line_d;

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  // A fill replaces the whole line; a write keeps unmasked bytes of the current line.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_merge
      assign line_d[gi*8 +: 8] = fill_en     ? fill_data[gi*8 +: 8] :
                                 wr_mask[gi] ? wr_data[gi*8 +: 8]   : rd_data[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
    end else if (wr_en) begin
      dirty_d[index] = 1'b1;
    end else if (clean_en) begin
      dirty_d[index] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en || wr_en) data_q[index] <= line_d;
    if (fill_en)          tag_q[index]  <= fill_tag;
  end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1 cache with pipelined hits and 256-bit line bursts.
// Optional hit/miss counters are built when L1_CACHE_PERF_CNT_EN is defined.
module l1_cache
  import cache_types::*;
#(
  parameter int SETS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_address,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_wdata,
  input  logic                 mem_stall,
  output logic                 mem_resp,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = LINE_ADDR_W - IDX_W;
  localparam logic [LINE_ADDR_W-1:0] IDX_MASK = LINE_ADDR_W'((1 << IDX_W) - 1);

  cache_state_t state_q, state_d;
  cache_req_t   rq_q, rq_d;

  logic                   arr_valid, arr_dirty;
  logic [TAG_W-1:0]       arr_tag;
  logic [LINE_BITS-1:0]   arr_data;
  logic [IDX_W-1:0]       arr_index;
  logic [LINE_ADDR_W-1:0] line_addr, rq_line_addr, wb_line_addr;
  logic [LINE_BYTES-1:0]  wr_mask;
  logic [LINE_BITS-1:0]   wr_data;
  logic                   tag_hit, req_hit, req_miss, in_idle, wr_en, fill_en, clean_en;
  logic [1:0]             unused_addr_lsb;

  assign unused_addr_lsb = mem_address[1:0];
  assign line_addr       = mem_address[31:OFFSET_W];
  assign arr_index       = rq_q.index[IDX_W-1:0];
  assign rq_line_addr    = (rq_q.tag << IDX_W) | rq_q.index;
  assign wb_line_addr    = (LINE_ADDR_W'(arr_tag) << IDX_W) | rq_q.index;

  assign in_idle  = (state_q == IDLE);
  assign tag_hit  = arr_valid && (rq_q.tag == LINE_ADDR_W'(arr_tag));
  assign req_hit  = in_idle && rq_q.valid && tag_hit;
  assign req_miss = in_idle && rq_q.valid && !tag_hit;

  assign mem_resp  = in_idle && !req_miss;
  assign mem_ready = req_hit;
  assign mem_rdata = req_hit ? arr_data[{rq_q.word, 5'b0} +: 32] : 32'd0;

  assign wr_en   = req_hit && rq_q.write;
  assign wr_mask = {{(LINE_BYTES-4){1'b0}}, rq_q.be} << {rq_q.word, 2'b00};
  assign wr_data = {(LINE_BITS/32){rq_q.wdata}};

  l1_cache_array #(
    .SETS (SETS)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (arr_index),
    .rd_valid  (arr_valid),
    .rd_dirty  (arr_dirty),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data),
    .wr_en     (wr_en),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .fill_en   (fill_en),
    .fill_tag  (rq_q.tag[TAG_W-1:0]),
    .fill_data (pmem_rdata),
    .clean_en  (clean_en)
  );

  // RQ only advances while the cache can accept; during a miss it is held regardless of stall.
  always_comb begin
    rq_d = rq_q;
    if (mem_resp && !mem_stall) begin
      if (mem_read || mem_write) begin
        rq_d.valid = 1'b1;
        rq_d.write = mem_write;
        rq_d.tag   = line_addr >> IDX_W;
        rq_d.index = line_addr & IDX_MASK;
        rq_d.word  = mem_address[4:2];
        rq_d.be    = mem_byte_enable;
        rq_d.wdata = mem_wdata;
      end else begin
        rq_d.valid = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = '0;
    fill_en      = 1'b0;
    clean_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_miss) state_d = (arr_valid && arr_dirty) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {wb_line_addr, {OFFSET_W{1'b0}}};
        pmem_wdata   = arr_data;
        if (pmem_resp) begin
          clean_en = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {rq_line_addr, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rq_q    <= '0;
    end else begin
      state_q <= state_d;
      rq_q    <= rq_d;
    end
  end

`ifdef L1_CACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic        fill_done_q, fill_done_d;

  // fill_done marks the replayed hit after a fill so a miss is only counted once.
  always_comb begin
    fill_done_d  = fill_done_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (mem_resp && !mem_stall) fill_done_d = 1'b0;
    if (fill_en)                fill_done_d = 1'b1;
    if (!mem_stall) begin
      if (req_hit && !fill_done_q) hit_count_d  = hit_count_q + 32'd1;
      if (req_miss)                miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_done_q  <= 1'b0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      fill_done_q  <= fill_done_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Directed self-checking bench for l1_cache (SETS=32): cold miss, hits, write merge,
// dirty eviction, stall hold and reset during a fill.
module tb_l1_cache;

`ifdef L1_CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0, mem_write = 1'b0, mem_stall = 1'b0;
  logic [31:0]  mem_address = 32'd0, mem_wdata = 32'd0;
  logic [3:0]   mem_byte_enable = 4'd0;
  logic         mem_resp, mem_ready;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [31:0]  hit_count, miss_count;

  int n_assert = 0;
  int n_fail   = 0;

  l1_cache #(.SETS(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_stall       (mem_stall),
    .mem_resp        (mem_resp),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA500_0000 | (base + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a line request, checks it, holds it 2 cycles, then pulses pmem_resp.
  task automatic serve(input string tag, input bit is_wr, input logic [31:0] addr,
                       input logic [255:0] rline, input logic [255:0] wline);
    int waited = 0;
    while (!(pmem_read || pmem_write) && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_req_seen"}, pmem_read || pmem_write, 1);
    chk({tag, "_pmem_write"}, pmem_write, is_wr);
    chk({tag, "_pmem_read"}, pmem_read, !is_wr);
    chk({tag, "_pmem_addr"}, pmem_address, addr);
    chk({tag, "_mem_resp"}, mem_resp, 0);
    if (is_wr) chk({tag, "_pmem_wdata"}, pmem_wdata, wline);
    tick();
    tick();
    chk({tag, "_strobe_held"}, is_wr ? pmem_write : pmem_read, 1);
    pmem_rdata = rline;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  initial begin
    logic [255:0] wb_line;

    // Reset
    tick();
    tick();
    chk("rst_mem_resp", mem_resp, 1);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr", pmem_address, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    rst_n = 1'b1;

    // 1: cold read miss on 0x40
    mem_read = 1'b1; mem_address = 32'h40;
    tick();
    mem_read = 1'b0;
    chk("t1_resp_low", mem_resp, 0);
    chk("t1_ready_low", mem_ready, 0);
    tick();
    serve("t1_fill", 1'b0, 32'h40, make_line(32'h40), '0);
    chk("t1_ready", mem_ready, 1);
    chk("t1_rdata", mem_rdata, 32'hA500_0040);
    chk("t1_pmem_idle", pmem_read, 0);
    chk("t1_miss_count", miss_count, cnt(1));
    chk("t1_hit_count", hit_count, cnt(0));

    // 2: back-to-back hits 0x44, 0x48
    mem_read = 1'b1; mem_address = 32'h44;
    tick();
    mem_address = 32'h48;
    chk("t2_ready_44", mem_ready, 1);
    chk("t2_rdata_44", mem_rdata, 32'hA500_0044);
    chk("t2_postfill_not_counted", hit_count, cnt(0));
    tick();
    mem_read = 1'b0;
    chk("t2_ready_48", mem_ready, 1);
    chk("t2_rdata_48", mem_rdata, 32'hA500_0048);
    chk("t2_no_pmem", pmem_read || pmem_write, 0);
    tick();
    chk("t2_ready_drop", mem_ready, 0);
    chk("t2_hit_count", hit_count, cnt(2));

    // 3: byte write then read back
    mem_write = 1'b1; mem_address = 32'h40; mem_byte_enable = 4'h2; mem_wdata = 32'h0000_AB00;
    tick();
    mem_write = 1'b0; mem_read = 1'b1;
    chk("t3_write_ready", mem_ready, 1);
    tick();
    mem_read = 1'b0;
    chk("t3_merged_rdata", mem_rdata, 32'hA500_AB40);
    tick();
    chk("t3_hit_count", hit_count, cnt(4));

    // 4: conflicting read 0x440 evicts dirty 0x40
    mem_read = 1'b1; mem_address = 32'h440;
    tick();
    mem_read = 1'b0;
    chk("t4_resp_low", mem_resp, 0);
    tick();
    wb_line = make_line(32'h40);
    wb_line[31:0] = 32'hA500_AB40;
    serve("t4_wb", 1'b1, 32'h40, '0, wb_line);
    serve("t4_fill", 1'b0, 32'h440, make_line(32'h440), '0);
    chk("t4_ready", mem_ready, 1);
    chk("t4_rdata", mem_rdata, 32'hA500_0440);
    chk("t4_miss_count", miss_count, cnt(2));

    // 5: stall holds outputs and blocks capture
    mem_read = 1'b1; mem_address = 32'h444;
    tick();
    mem_stall = 1'b1; mem_address = 32'h448;
    for (int i = 0; i < 3; i++) begin
      chk("t5_ready_held", mem_ready, 1);
      chk("t5_rdata_held", mem_rdata, 32'hA500_0444);
      chk("t5_hit_frozen", hit_count, cnt(4));
      tick();
    end
    mem_stall = 1'b0; mem_read = 1'b0;
    tick();
    chk("t5_not_captured", mem_ready, 0);
    chk("t5_hit_after", hit_count, cnt(5));

    // 6: reset during fill
    mem_read = 1'b1; mem_address = 32'h40;
    tick();
    mem_read = 1'b0;
    tick();
    chk("t6_fill_started", pmem_read, 1);
    chk("t6_fill_addr", pmem_address, 32'h40);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_pmem_read_drop", pmem_read, 0);
    chk("t6_resp_high", mem_resp, 1);
    chk("t6_counter_clear", miss_count, 0);
    pmem_rdata = make_line(32'h40);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    chk("t6_late_resp_ignored", pmem_read || pmem_write, 0);
    mem_read = 1'b1; mem_address = 32'h40;
    tick();
    mem_read = 1'b0;
    chk("t6_now_misses", mem_resp, 0);
    tick();
    serve("t6_refill", 1'b0, 32'h40, make_line(32'h40), '0);
    chk("t6_rdata", mem_rdata, 32'hA500_0040);
    chk("t6_miss_count", miss_count, cnt(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
